// File: rtl/sram_ctl.sv
// Clocked request/acknowledge engine for external asynchronous SRAM.
// Every pin is registered; the top level owns the tri-state data pads.
//
// state  | meaning
// IDLE   | pins released, waiting for req
// SETUP  | address, chip enable, lanes (and write data) applied; strobes high
// STROBE | oe_n or we_n low for RD_WAIT / WR_WAIT cycles
// HOLD   | strobes high, ack pulsed; write pins held for data hold time
module sram_ctl #(
  parameter int ADDR_W  = 18,
  parameter int CS_BITS = 1,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  localparam int NCS  = 1 << CS_BITS,
  localparam int WA_W = ADDR_W - 1 - CS_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic              byte_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              ready,
  output logic              ack,
  output logic [WA_W-1:0]   ram_a,
  output logic [NCS-1:0]    ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_ub_n,
  output logic              ram_lb_n,
  output logic [15:0]       ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [15:0]       ram_dq_in
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_WAIT - 1);

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              q_we, q_byte;
  logic [ADDR_W-1:0] q_addr;
  logic [15:0]       q_wdata;

  logic              accept, last_strobe;
  logic              cur_we, cur_byte;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0]       cur_wdata, cur_dq;
  logic              cur_ub_n, cur_lb_n;
  logic [NCS-1:0]    ce_sel_n;

  assign accept      = ready & req;
  assign last_strobe = (state == STROBE) && (cnt == '0);

  // Pins for SETUP are computed from the request being accepted at this edge.
  assign cur_we    = accept ? we      : q_we;
  assign cur_byte  = accept ? byte_op : q_byte;
  assign cur_addr  = accept ? addr    : q_addr;
  assign cur_wdata = accept ? wdata   : q_wdata;
  assign cur_ub_n  = cur_byte & ~cur_addr[0];
  assign cur_lb_n  = cur_byte &  cur_addr[0];
  assign cur_dq    = cur_byte ? {cur_wdata[7:0], cur_wdata[7:0]} : cur_wdata;

  generate
    if (CS_BITS == 0) begin : g_one_cs
      assign ce_sel_n = '0;
    end else begin : g_multi_cs
      assign ce_sel_n = ~(NCS'(1) << cur_addr[ADDR_W-1 -: CS_BITS]);
    end
  endgenerate

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? SETUP : IDLE;
      SETUP:   state_nx = STROBE;
      STROBE:  state_nx = last_strobe ? HOLD : STROBE;
      HOLD:    state_nx = accept ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      q_we       <= 1'b0;
      q_byte     <= 1'b0;
      q_addr     <= '0;
      q_wdata    <= '0;
      ready      <= 1'b1;
      ack        <= 1'b0;
      rdata      <= '0;
      ram_a      <= '0;
      ram_ce_n   <= '1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_ub_n   <= 1'b1;
      ram_lb_n   <= 1'b1;
      ram_dq_out <= '0;
      ram_dq_oe  <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == IDLE) || (state_nx == HOLD);
      ack   <= (state_nx == HOLD);

      if (accept) begin
        q_we    <= we;
        q_byte  <= byte_op;
        q_addr  <= addr;
        q_wdata <= wdata;
      end

      if (state == SETUP)
        cnt <= q_we ? WR_LD : RD_LD;
      else if (state == STROBE)
        cnt <= cnt - CNT_W'(1);

      if (last_strobe && !q_we)
        rdata <= q_byte ? {8'h00, (q_addr[0] ? ram_dq_in[15:8] : ram_dq_in[7:0])}
                        : ram_dq_in;

      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      case (state_nx)
        SETUP: begin
          ram_a     <= cur_addr[ADDR_W-CS_BITS-1:1];
          ram_ce_n  <= ce_sel_n;
          ram_ub_n  <= cur_ub_n;
          ram_lb_n  <= cur_lb_n;
          ram_dq_oe <= cur_we;
          if (cur_we)
            ram_dq_out <= cur_dq;
        end
        STROBE: begin
          ram_oe_n <= q_we;
          ram_we_n <= ~q_we;
        end
        HOLD: begin
          // A write keeps everything driven so data outlives the we_n rise.
          if (!q_we) begin
            ram_ce_n <= '1;
            ram_ub_n <= 1'b1;
            ram_lb_n <= 1'b1;
          end
        end
        default: begin
          ram_ce_n  <= '1;
          ram_ub_n  <= 1'b1;
          ram_lb_n  <= 1'b1;
          ram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctl.sv
// Directed bench for sram_ctl: a word-array SRAM model on the main instance,
// plus a four-chip instance with unequal strobe widths.
module tb_sram_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we, byte_op;
  logic [17:0] addr;
  logic [15:0] wdata, rdata;
  logic        ready, ack;
  logic [15:0] ram_a;
  logic [1:0]  ram_ce_n;
  logic        ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n;
  logic [15:0] ram_dq_out, ram_dq_in;
  logic        ram_dq_oe;

  logic        req2, we2, byte_op2;
  logic [17:0] addr2;
  logic [15:0] wdata2, rdata2;
  logic        ready2, ack2;
  logic [14:0] ram_a2;
  logic [3:0]  ram_ce_n2;
  logic        ram_oe_n2, ram_we_n2, ram_ub_n2, ram_lb_n2;
  logic [15:0] ram_dq_out2, ram_dq_in2;
  logic        ram_dq_oe2;

  int n_tests = 0;
  int n_fail  = 0;
  int inv_viol = 0;

  logic [15:0] s_a, s_dq, s_rd;
  logic [1:0]  s_ce;
  logic        s_ub, s_lb, s_oe;
  int          acyc, welow;

  sram_ctl #(.ADDR_W(18), .CS_BITS(1), .RD_WAIT(2), .WR_WAIT(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .byte_op(byte_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .ack(ack),
    .ram_a(ram_a), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n), .ram_dq_out(ram_dq_out),
    .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in)
  );

  sram_ctl #(.ADDR_W(18), .CS_BITS(2), .RD_WAIT(3), .WR_WAIT(1)) u_cs2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .we(we2), .byte_op(byte_op2),
    .addr(addr2), .wdata(wdata2), .rdata(rdata2), .ready(ready2), .ack(ack2),
    .ram_a(ram_a2), .ram_ce_n(ram_ce_n2), .ram_oe_n(ram_oe_n2), .ram_we_n(ram_we_n2),
    .ram_ub_n(ram_ub_n2), .ram_lb_n(ram_lb_n2), .ram_dq_out(ram_dq_out2),
    .ram_dq_oe(ram_dq_oe2), .ram_dq_in(ram_dq_in2)
  );

  initial forever #5 clk = ~clk;

  // SRAM model: two chips of 64K words, lane-masked writes.
  logic [15:0] mem [0:131071];
  logic [16:0] key;
  assign key = {(ram_ce_n == 2'b01), ram_a};
  assign ram_dq_in = (!ram_oe_n && ram_ce_n != 2'b11) ? mem[key] : 16'h0000;

  always @(posedge clk) begin
    if (reset_n && !ram_we_n && ram_ce_n != 2'b11) begin
      if (!ram_ub_n) mem[key][15:8] <= ram_dq_out[15:8];
      if (!ram_lb_n) mem[key][7:0]  <= ram_dq_out[7:0];
    end
  end

  logic        p_we_n = 1'b1;
  logic [15:0] p_a = '0;
  logic [1:0]  p_ce = 2'b11;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_dq_oe && !ram_oe_n) inv_viol++;
      if (!ram_we_n && !ram_oe_n) inv_viol++;
      if ($countones(~ram_ce_n) > 1) inv_viol++;
      if (p_we_n && !ram_we_n && (ram_a != p_a || ram_ce_n != p_ce)) inv_viol++;
    end
    p_we_n = ram_we_n;
    p_a    = ram_a;
    p_ce   = ram_ce_n;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack (HOLD) cycle.
  task automatic access(input logic w, input logic b, input logic [17:0] a, input logic [15:0] d);
    int n;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    we = w; byte_op = b; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0; we = ~w; byte_op = ~b; addr = 18'h3FFFF; wdata = 16'hFFFF;
    s_a = ram_a; s_ce = ram_ce_n; s_ub = ram_ub_n; s_lb = ram_lb_n;
    s_dq = ram_dq_out; s_oe = ram_dq_oe;
    acyc = 1; welow = 0;
    while (!ack && acyc < 40) begin
      if (!ram_we_n) welow++;
      @(negedge clk);
      acyc++;
    end
    s_rd = rdata;
  endtask

  initial begin
    int c, first;
    logic seen_ack;
    reset_n = 1'b0; req = 0; we = 0; byte_op = 0; addr = '0; wdata = '0;
    req2 = 0; we2 = 0; byte_op2 = 0; addr2 = '0; wdata2 = '0; ram_dq_in2 = 16'hC3A5;
    repeat (3) @(negedge clk);
    check("reset ctl pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n, ram_dq_oe, ack, ready},
          9'b11_1111_001);
    check("reset data regs", {ram_a, ram_dq_out, rdata}, 48'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after release", ready, 1'b1);

    access(1'b1, 1'b0, 18'h00100, 16'h1234);
    check("wr setup a/ce", {s_a, s_ce}, {16'h0080, 2'b10});
    check("wr setup lanes/oe/dq", {s_ub, s_lb, s_oe, s_dq}, {1'b0, 1'b0, 1'b1, 16'h1234});
    check("wr we_n low cycles", welow, 2);
    check("wr ack cycle", acyc, 4);

    access(1'b0, 1'b0, 18'h00100, 16'h0);
    check("rd word data", s_rd, 16'h1234);
    check("rd ack cycle", acyc, 4);
    check("rd setup dq_oe", s_oe, 1'b0);

    access(1'b0, 1'b1, 18'h00101, 16'h0);
    check("byte rd hi", {s_rd, s_ub, s_lb}, {16'h0012, 1'b0, 1'b1});
    access(1'b0, 1'b1, 18'h00100, 16'h0);
    check("byte rd lo", {s_rd, s_ub, s_lb}, {16'h0034, 1'b1, 1'b0});

    access(1'b1, 1'b1, 18'h00101, 16'h00AB);
    check("byte wr dq/lanes", {s_dq, s_ub, s_lb}, {16'hABAB, 1'b0, 1'b1});
    access(1'b0, 1'b0, 18'h00100, 16'h0);
    check("word rd after byte wr", s_rd, 16'hAB34);

    access(1'b1, 1'b0, 18'h20000, 16'h0F0F);
    check("cs1 a/ce", {s_a, s_ce}, {16'h0000, 2'b01});
    access(1'b0, 1'b0, 18'h20000, 16'h0);
    check("cs1 readback", s_rd, 16'h0F0F);

    for (int i = 0; i < 2; i++) begin
      we2 = (i == 0); byte_op2 = 1'b0; addr2 = 18'h30002; wdata2 = 16'h1357; req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0; addr2 = 18'h0;
      if (i == 0) check("cs2 ce/a/dq", {ram_ce_n2, ram_a2, ram_dq_out2}, {4'b0111, 15'h0001, 16'h1357});
      c = 1;
      while (!ack2 && c < 40) begin @(negedge clk); c++; end
      check("cs2 ack cycle", c, (i == 0) ? 3 : 5);
      if (i == 1) check("cs2 rdata", rdata2, 16'hC3A5);
    end

    // Back-to-back: write then read with req held through the write's HOLD.
    we = 1'b1; byte_op = 1'b0; addr = 18'h00200; wdata = 16'h5A5A; req = 1'b1;
    @(negedge clk);
    we = 1'b0; wdata = 16'h0000;
    check("b2b busy in setup", ready, 1'b0);
    c = 1;
    while (!ack && c < 40) begin @(negedge clk); c++; end
    first = c;
    check("b2b first ack", first, 4);
    check("b2b ready in hold", ready, 1'b1);
    @(negedge clk); c++;
    req = 1'b0;
    check("b2b read setup", {ram_ce_n, ram_dq_oe, ram_oe_n}, {2'b10, 1'b0, 1'b1});
    while (!ack && c < 40) begin @(negedge clk); c++; end
    check("b2b ack spacing", c - first, 4);
    check("b2b read data", rdata, 16'h5A5A);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    we = 1'b1; byte_op = 1'b0; addr = 18'h00300; wdata = 16'h7777; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("mid strobe we low", ram_we_n, 1'b0);
    #1 reset_n = 1'b0;
    #1 check("async reset pins", {ram_we_n, ram_ce_n, ram_dq_oe}, {1'b1, 2'b11, 1'b0});
    seen_ack = 1'b0;
    repeat (3) begin @(negedge clk); if (ack) seen_ack = 1'b1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (ack) seen_ack = 1'b1; end
    check("no ack after reset", seen_ack, 1'b0);
    check("post reset state", {ready, ram_a, rdata}, {1'b1, 16'h0, 16'h0});
    access(1'b1, 1'b0, 18'h00300, 16'h4321);
    check("post reset wr ack", acyc, 4);
    access(1'b0, 1'b0, 18'h00300, 16'h0);
    check("post reset rd data", s_rd, 16'h4321);

    @(negedge clk);
    check("pin invariants", inv_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
